// File: rtl/instr_mem_resp_pkg.sv
// Shared definitions for the instruction-memory responder: fetch interface
// widths, the NOP encoding and the response record carried down the pipe.
package instr_mem_resp_pkg;

    localparam int XLEN                 = 32;
    localparam int INSTR_MEM_ADDR_WIDTH = 32;
    localparam int INSTR_MEM_WIDTH      = 32;
    localparam int INSTR_MEM_TAG_WIDTH  = 32;

    // addi x0, x0, 0 -- returned for fetches outside the array
    localparam logic [INSTR_MEM_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic                           valid;
        logic                           err;
        logic [INSTR_MEM_WIDTH-1:0]     rdata;
        logic [INSTR_MEM_TAG_WIDTH-1:0] tag;
    } imem_rsp_t;

    localparam int IMEM_RSP_W = $bits(imem_rsp_t);

    // Saturating 32-bit increment used by the request counter
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/instr_mem_resp_delay_line.sv
// Response delay line: STAGES resettable register stages carrying an
// imem_rsp_t from its input to its output. STAGES=0 is a plain wire.
import instr_mem_resp_pkg::*;

// Resettable enabled D flip-flop, the building block of the delay line
module dff_rst_en #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Capture on enable, clear on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q <= '0;
        end else if (i_en) begin
            // NOTE: non-blocking so every stage samples its neighbour's old value
            o_q <= i_d;
        end
    end

endmodule

module instr_mem_delay_line #(
    parameter int STAGES = 0
) (
    input  logic      clk,
    input  logic      rst_n,
    input  imem_rsp_t i_rsp,
    output imem_rsp_t o_rsp
);

    imem_rsp_t w_chain [STAGES+1];

    assign w_chain[0] = i_rsp;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        dff_rst_en #(
            .WIDTH (IMEM_RSP_W)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .i_en  (1'b1),
            .i_d   (w_chain[k]),
            .o_q   (w_chain[k+1])
        );
    end

    assign o_rsp = w_chain[STAGES];

endmodule

// File: rtl/instr_mem_resp.sv
// Instruction-memory responder for the IFU fetch port. One request per
// cycle, answered LATENCY cycles later with its tag, in order, with no
// backpressure. The word array is loaded through a backdoor write port
// and is never cleared by reset.
// Optional: define INSTR_MEM_OOR_ERR_EN to add rsp_err, flagging
// out-of-range fetches (answered with NOP_INSTR) and misaligned fetches.
module instr_mem_resp
    import instr_mem_resp_pkg::*;
#(
    parameter int    DEPTH     = 1024,
    parameter int    LATENCY   = 1,
    parameter string INIT_FILE = ""
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [INSTR_MEM_ADDR_WIDTH-1:0] req_addr,
    input  logic                            req_valid,
    input  logic [INSTR_MEM_TAG_WIDTH-1:0]  req_tag,
    output logic [INSTR_MEM_WIDTH-1:0]      rsp_rdata,
    output logic                            rsp_valid,
    output logic [INSTR_MEM_TAG_WIDTH-1:0]  rsp_tag,
    input  logic                            load_we,
    input  logic [$clog2(DEPTH)-1:0]        load_addr,
    input  logic [INSTR_MEM_WIDTH-1:0]      load_wdata,
`ifdef INSTR_MEM_OOR_ERR_EN
    output logic                            rsp_err,
`endif
    output logic [31:0]                     req_count
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [INSTR_MEM_WIDTH-1:0] r_mem [DEPTH];
    imem_rsp_t                  r_stage0;
    imem_rsp_t                  w_rsp_out;
    logic [31:0]                r_req_count;
    logic [IDX_W-1:0]           w_idx;
    logic                       w_oor;
    logic                       w_misalign;

    // Aligned word index; low two bits and bits above the array are dropped
    assign w_idx = req_addr[IDX_W+1:2];

`ifdef INSTR_MEM_OOR_ERR_EN
    assign w_oor      = |req_addr[INSTR_MEM_ADDR_WIDTH-1:IDX_W+2];
    assign w_misalign = |req_addr[1:0];
`else
    // Out-of-range addresses simply wrap; the ignored bits are not inspected
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{req_addr[INSTR_MEM_ADDR_WIDTH-1:IDX_W+2], req_addr[1:0]};
    assign w_oor      = 1'b0;
    assign w_misalign = 1'b0;
`endif

    // Backdoor write port; runs regardless of reset so images load in reset
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset -- contents must survive rst_n
        if (load_we) begin
            r_mem[load_addr] <= load_wdata;
        end
    end

    // Stage 0: synchronous array read plus tag/valid capture (read-before-write)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage0 <= '0;
        end else if (req_valid) begin
            r_stage0.valid <= 1'b1;
            r_stage0.err   <= w_oor | w_misalign;
            r_stage0.rdata <= w_oor ? NOP_INSTR : r_mem[w_idx];
            r_stage0.tag   <= req_tag;
        end else begin
            // Data and tag hold so the response port keeps its last value
            r_stage0.valid <= 1'b0;
            r_stage0.err   <= 1'b0;
        end
    end

    // Saturating count of accepted requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_count <= '0;
        end else if (req_valid) begin
            r_req_count <= sat_inc32(r_req_count);
        end
    end

    instr_mem_delay_line #(
        .STAGES (LATENCY - 1)
    ) u_delay_line (
        .clk   (clk),
        .rst_n (rst_n),
        .i_rsp (r_stage0),
        .o_rsp (w_rsp_out)
    );

    assign rsp_valid = w_rsp_out.valid;
    assign rsp_rdata = w_rsp_out.rdata;
    assign rsp_tag   = w_rsp_out.tag;
    assign req_count = r_req_count;

`ifdef INSTR_MEM_OOR_ERR_EN
    assign rsp_err = w_rsp_out.err;
`else
    logic w_unused_err;
    assign w_unused_err = w_rsp_out.err;
`endif

endmodule

// File: tb/tb_instr_mem_resp.sv
// Bench for instr_mem_resp: two instances (LATENCY=1/DEPTH=1024 and
// LATENCY=3/DEPTH=64) share one randomized stimulus stream. Expected
// responses come from a per-cycle request log: the answer seen in cycle c
// is the request logged in cycle c-LATENCY, with data captured from a
// model array at request time.
module tb_instr_mem_resp;
    import instr_mem_resp_pkg::*;

    localparam int NCYC = 2400;
    localparam int LAT [2] = '{1, 3};
    localparam int DEP [2] = '{1024, 64};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_valid = 1'b0;
    logic [31:0] req_tag = '0;
    logic        load_we = 1'b0;
    logic [9:0]  load_addr = '0;
    logic [31:0] load_wdata = '0;

    logic [31:0] rdata1, tag1, cnt1, rdata3, tag3, cnt3;
    logic        valid1, valid3;
    logic        err1, err3;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] m1 [1024];
    logic [31:0] m3 [64];
    bit          log_v [NCYC];
    logic [31:0] log_t [NCYC];
    logic [31:0] log_d [2][NCYC];
    bit          log_e [2][NCYC];
    int          reset_mark = 0;
    int          cyc = 0;
    logic [31:0] model_cnt = '0;

    always #5 clk = ~clk;

    instr_mem_resp #(.DEPTH(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_addr(req_addr), .req_valid(req_valid),
        .req_tag(req_tag), .rsp_rdata(rdata1), .rsp_valid(valid1), .rsp_tag(tag1),
        .load_we(load_we), .load_addr(load_addr), .load_wdata(load_wdata),
`ifdef INSTR_MEM_OOR_ERR_EN
        .rsp_err(err1),
`endif
        .req_count(cnt1)
    );

    instr_mem_resp #(.DEPTH(64), .LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_addr(req_addr), .req_valid(req_valid),
        .req_tag(req_tag), .rsp_rdata(rdata3), .rsp_valid(valid3), .rsp_tag(tag3),
        .load_we(load_we), .load_addr(load_addr[5:0]), .load_wdata(load_wdata),
`ifdef INSTR_MEM_OOR_ERR_EN
        .rsp_err(err3),
`endif
        .req_count(cnt3)
    );

`ifndef INSTR_MEM_OOR_ERR_EN
    assign err1 = 1'b0;
    assign err3 = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    endtask

    // Expected port values of instance d in check cycle c
    function automatic void expect_at(input int d, input int c, output bit ev,
                                      output logic [31:0] ed, output logic [31:0] et,
                                      output bit ee);
        int k;
        ev = 1'b0; ed = '0; et = '0; ee = 1'b0;
        k = c - LAT[d];
        for (int j = k; j >= reset_mark && j >= 0; j--) begin
            if (log_v[j]) begin
                ev = (j == k);
                ed = log_d[d][j];
                et = log_t[j];
                ee = (j == k) ? log_e[d][j] : 1'b0;
                break;
            end
        end
    endfunction

    task automatic check_dut(input int d, input logic v, input logic [31:0] data,
                             input logic [31:0] tag, input logic err);
        bit ev, ee;
        logic [31:0] ed, et;
        expect_at(d, cyc, ev, ed, et, ee);
        check(d == 0 ? "l1_valid" : "l3_valid", {31'd0, v}, {31'd0, ev});
        check(d == 0 ? "l1_rdata" : "l3_rdata", data, ed);
        check(d == 0 ? "l1_tag"   : "l3_tag",   tag,  et);
`ifdef INSTR_MEM_OOR_ERR_EN
        check(d == 0 ? "l1_err"   : "l3_err",   {31'd0, err}, {31'd0, ee});
`else
        if (err !== 1'b0) check("err_tied", {31'd0, err}, 32'd0);
`endif
    endtask

    // One cycle: check outputs at the negedge, then drive the next edge's inputs
    task automatic step(input bit rst, input bit v, input logic [31:0] a, input logic [31:0] t,
                        input bit we, input logic [9:0] la, input logic [31:0] wd,
                        input bit frc);
        int idx;
        bit oor, mis;
        @(negedge clk);
        check_dut(0, valid1, rdata1, tag1, err1);
        check_dut(1, valid3, rdata3, tag3, err3);
        check("l1_count", cnt1, model_cnt);
        check("l3_count", cnt3, model_cnt);
        if (frc) begin
            force dut1.r_req_count = 32'hFFFF_FFFE;
            force dut3.r_req_count = 32'hFFFF_FFFE;
            #1;
            release dut1.r_req_count;
            release dut3.r_req_count;
            model_cnt = 32'hFFFF_FFFE;
        end
        if (!rst) begin
            reset_mark = cyc;
            model_cnt  = '0;
            v          = 1'b0;
        end
        rst_n      = rst;
        req_valid  = v;
        req_addr   = a;
        req_tag    = t;
        load_we    = we;
        load_addr  = la;
        load_wdata = wd;
        log_v[cyc] = v;
        log_t[cyc] = t;
        for (int d = 0; d < 2; d++) begin
            idx = int'((a >> 2) % DEP[d]);
            mis = (a % 4) != 0;
            oor = (a / (DEP[d] * 4)) != 0;
`ifdef INSTR_MEM_OOR_ERR_EN
            log_e[d][cyc] = oor || mis;
            log_d[d][cyc] = oor ? NOP_INSTR : (d == 0 ? m1[idx] : m3[idx]);
`else
            log_e[d][cyc] = 1'b0;
            log_d[d][cyc] = (d == 0) ? m1[idx] : m3[idx];
`endif
        end
        if (v && model_cnt != 32'hFFFF_FFFF) model_cnt = model_cnt + 1;
        if (we) begin
            m1[la]       = wd;
            m3[la % 64]  = wd;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] t);
        step(1, 1, a, t, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] a;
        // Fill the whole array through the backdoor; the first writes land in reset
        for (int i = 0; i < 1024; i++)
            step(i >= 8, 0, 0, 0, 1, 10'(i), $urandom, 0);
        step(1, 0, 0, 0, 1, 10'd0, 32'h0000_0093, 0);
        step(1, 0, 0, 0, 1, 10'd1, 32'h0010_0113, 0);
        idle(2);

        // Back-to-back fetches of words 0 and 1
        req(32'h0, 32'h0);
        req(32'h4, 32'h4);
        idle(4);

        // Requests with a bubble: answers keep order and the bubble
        req(32'h8, 32'h100);
        req(32'hC, 32'h101);
        idle(1);
        req(32'h10, 32'h103);
        idle(4);

        // Read-before-write on index 5, then read the new value
        step(1, 1, 32'h14, 32'h55, 1, 10'd5, 32'hDEAD_BEEF, 0);
        req(32'h14, 32'h56);
        idle(4);

        // Reset with two fetches in flight; array contents must survive
        req(32'h0, 32'h200);
        req(32'h4, 32'h201);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle(5);
        req(32'h0, 32'h202);
        idle(4);

        // Counter saturation
        step(1, 1, 32'h4, 32'h300, 0, 0, 0, 1);
        req(32'h8, 32'h301);
        req(32'hC, 32'h302);
        idle(3);

        // Out-of-range and misaligned fetches
        req(32'h1000, 32'h400);
        req(32'h2, 32'h401);
        idle(4);

        // Randomized traffic with writes and occasional resets
        for (int i = 0; i < 1000; i++) begin
            a = $urandom_range(0, 32'h3FFF);
            if ($urandom_range(0, 7) != 0) a = a & ~32'h3;
            step($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7, a, $urandom,
                 $urandom_range(0, 4) == 0, 10'($urandom_range(0, 1023)), $urandom, 0);
        end
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
